mem_arbiter: RTL

//   Shares one memory port between instruction fetch (IF) and load/store (LS) requesters.

---
 rtl/mem_arbiter.sv | 87 ++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and load/store, one transaction at a time
module mem_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_req_ready,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rsp_data,
  input  logic                ls_req_valid,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic                ls_wen,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wmask,
  output logic                ls_req_ready,
  output logic                ls_rsp_valid,
  output logic [DATA_W-1:0]   ls_rsp_data,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_data
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t              state;
  logic                owner_ls;
  logic [SW-1:0]       streak;
  logic [ADDR_W-1:0]   addr_q;
  logic                wen_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wmask_q;
  logic                idle;
  logic                ls_win;
  logic                if_win;
  // Readies are gated by rst so they read 0 while reset is held, even with requests pending
  always_comb begin
    idle   = rst && state == IDLE;
    ls_win = ls_req_valid && (!if_req_valid || streak != SMAX);
    if_win = if_req_valid && !ls_win;
  end
  assign if_req_ready  = idle && if_win;
  assign ls_req_ready  = idle && ls_win;
  assign mem_req_valid = state == REQ;
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;
  assign if_rsp_valid  = state == WAIT && !owner_ls && mem_rsp_valid;
  assign ls_rsp_valid  = state == WAIT && owner_ls && mem_rsp_valid;
  assign if_rsp_data   = mem_rsp_data;
  assign ls_rsp_data   = mem_rsp_data;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      owner_ls <= 1'b0;
      streak   <= '0;
      addr_q   <= '0;
      wen_q    <= 1'b0;
      wdata_q  <= '0;
      wmask_q  <= '0;
    end else begin
      case (state)
        IDLE: if (ls_win || if_win) begin
          state    <= REQ;
          owner_ls <= ls_win;
          addr_q   <= ls_win ? ls_addr : if_addr;
          wen_q    <= ls_win && ls_wen;
          wdata_q  <= ls_win ? ls_wdata : '0;
          wmask_q  <= ls_win ? ls_wmask : '0;
          streak   <= (ls_win && if_req_valid) ? (streak == SMAX ? SMAX : streak + 1'b1) : '0;
        end
        REQ:  if (mem_req_ready) state <= WAIT;
        WAIT: if (mem_rsp_valid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
